// File: rtl/mac_stream_if.sv
// Operand-in / result-out bundle for the streaming MAC.
// master = producer/consumer side (drives operands, accepts results); slave = MAC side.
// Widths follow the MAC instance: DATA_W operands, ACC_W sum, CNT_W term count.
interface mac_stream_if #(
  parameter int DATA_W = 64,
  parameter int ACC_W  = 2*64+8,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );
endinterface

// File: rtl/mac_stream.sv
// Pipelined streaming multiply-accumulate; in_last closes a vector and emits sum/count/overflow.
// Latency: last beat accepted in cycle t -> out_valid in cycle t+MUL_STAGES+1; one beat per cycle.
// Backpressure: a held result (out_valid & ~out_ready) freezes pipeline and accumulator, in_ready=0.
module mac_stream #(
  parameter int DATA_W     = 64,
  parameter int GUARD      = 8,
  parameter int ACC_W      = 2*DATA_W+GUARD,
  parameter bit SIGNED     = 1'b0,
  parameter int MUL_STAGES = 2,
  parameter int CNT_W      = 16
) (
  input logic         clk,
  input logic         reset,
  mac_stream_if.slave bus
);
  localparam int PROD_W = 2*DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              stall;
  logic              accept;
  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] b_ext;
  logic [PROD_W-1:0] prod;

  // Product pipeline: index MUL_STAGES-1 is the head feeding the accumulator.
  logic [PROD_W-1:0]     p_dat_q [MUL_STAGES];
  logic [MUL_STAGES-1:0] p_vld_q;
  logic [MUL_STAGES-1:0] p_last_q;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] sum;
  logic             step_ovf;
  logic [CNT_W-1:0] cnt_inc;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;

  assign stall         = out_valid_q & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign accept        = bus.in_valid & ~stall;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;

  // Full-width multiply: operands zero/sign-extended to 2*DATA_W so the low half is exact either way.
  always_comb begin
    a_ext = PROD_W'(bus.in_a);
    b_ext = PROD_W'(bus.in_b);
    if (SIGNED) begin
      if (bus.in_a[DATA_W-1]) a_ext[PROD_W-1:DATA_W] = '1;
      if (bus.in_b[DATA_W-1]) b_ext[PROD_W-1:DATA_W] = '1;
    end
    prod = a_ext * b_ext;
  end

  // Product pipeline advances only when the output is not being held.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_vld_q  <= '0;
      p_last_q <= '0;
      for (int i = 0; i < MUL_STAGES; i++) p_dat_q[i] <= '0;
    end else if (!stall) begin
      p_vld_q[0]  <= accept;
      p_last_q[0] <= accept & bus.in_last;
      p_dat_q[0]  <= prod;
      for (int i = 1; i < MUL_STAGES; i++) begin
        p_vld_q[i]  <= p_vld_q[i-1];
        p_last_q[i] <= p_last_q[i-1];
        p_dat_q[i]  <= p_dat_q[i-1];
      end
    end
  end

  // Extend head product into the guard bits, add, and detect this step's overflow.
  always_comb begin
    prod_ext = ACC_W'(p_dat_q[MUL_STAGES-1]);
    if (SIGNED && p_dat_q[MUL_STAGES-1][PROD_W-1]) begin
      for (int i = PROD_W; i < ACC_W; i++) prod_ext[i] = 1'b1;
    end
    sum_wide = {1'b0, acc_q} + {1'b0, prod_ext};
    sum      = sum_wide[ACC_W-1:0];
    if (SIGNED) begin
      step_ovf = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    end else begin
      step_ovf = sum_wide[ACC_W];
    end
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  // Accumulate or close the vector; a closing beat also clears state so the next vector starts clean.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    if (!stall) begin
      // Not stalled means any held result is being accepted this cycle.
      out_valid_d = 1'b0;
      if (p_vld_q[MUL_STAGES-1]) begin
        if (p_last_q[MUL_STAGES-1]) begin
          out_data_d  = sum;
          out_count_d = cnt_inc;
          out_ovf_d   = ovf_q | step_ovf;
          out_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
        end else begin
          acc_d = sum;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | step_ovf;
        end
      end
    end
  end

  // Accumulator and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_mac_stream.sv
// Bench for mac_stream: three instances (64-bit unsigned, 8-bit signed, 8-bit unsigned no guard).
// Results are captured on acceptance and compared against sums computed directly from operands.
// Scenario tasks run in sequence from one initial block.
`timescale 1ns/1ps
module tb_mac_stream;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int acc_cyc0 = 0;

  mac_stream_if #(.DATA_W(64), .ACC_W(136), .CNT_W(16)) if0 ();
  mac_stream_if #(.DATA_W(8),  .ACC_W(24),  .CNT_W(16)) if1 ();
  mac_stream_if #(.DATA_W(8),  .ACC_W(16),  .CNT_W(16)) if2 ();

  mac_stream #(.DATA_W(64), .GUARD(8), .SIGNED(1'b0), .MUL_STAGES(2), .CNT_W(16))
    dut0 (.clk(clk), .reset(reset), .bus(if0));
  mac_stream #(.DATA_W(8), .GUARD(8), .SIGNED(1'b1), .MUL_STAGES(2), .CNT_W(16))
    dut1 (.clk(clk), .reset(reset), .bus(if1));
  mac_stream #(.DATA_W(8), .GUARD(0), .SIGNED(1'b0), .MUL_STAGES(2), .CNT_W(16))
    dut2 (.clk(clk), .reset(reset), .bus(if2));

  typedef struct {
    logic [135:0] d;
    logic [15:0]  c;
    logic         o;
    int           cy;
  } rec_t;
  rec_t obs0[$];
  rec_t obs1[$];
  rec_t obs2[$];

  // Capture every accepted result with the cycle it was presented.
  always @(negedge clk) begin
    if (!reset && if0.out_valid && if0.out_ready)
      obs0.push_back('{d: if0.out_data, c: if0.out_count, o: if0.out_ovf, cy: cyc});
    if (!reset && if1.out_valid && if1.out_ready)
      obs1.push_back('{d: 136'(if1.out_data), c: if1.out_count, o: if1.out_ovf, cy: cyc});
    if (!reset && if2.out_valid && if2.out_ready)
      obs2.push_back('{d: 136'(if2.out_data), c: if2.out_count, o: if2.out_ovf, cy: cyc});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send0(input logic [63:0] a, input logic [63:0] b, input logic last);
    int n;
    n = 0;
    if0.in_valid = 1'b1; if0.in_a = a; if0.in_b = b; if0.in_last = last;
    @(negedge clk);
    while (!if0.in_ready && n < 300) begin @(negedge clk); n++; end
    if (!if0.in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send0_timeout: in_ready=%0b required 1", if0.in_ready);
    end
    acc_cyc0 = cyc;
    @(posedge clk); #1;
    if0.in_valid = 1'b0; if0.in_a = {$urandom, $urandom}; if0.in_b = {$urandom, $urandom};
    if0.in_last = 1'($urandom);
  endtask

  task automatic send1(input logic [7:0] a, input logic [7:0] b, input logic last);
    int n;
    n = 0;
    if1.in_valid = 1'b1; if1.in_a = a; if1.in_b = b; if1.in_last = last;
    @(negedge clk);
    while (!if1.in_ready && n < 300) begin @(negedge clk); n++; end
    if (!if1.in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send1_timeout: in_ready=%0b required 1", if1.in_ready);
    end
    @(posedge clk); #1;
    if1.in_valid = 1'b0; if1.in_a = 8'($urandom); if1.in_b = 8'($urandom); if1.in_last = 1'($urandom);
  endtask

  task automatic send2(input logic [7:0] a, input logic [7:0] b, input logic last);
    int n;
    n = 0;
    if2.in_valid = 1'b1; if2.in_a = a; if2.in_b = b; if2.in_last = last;
    @(negedge clk);
    while (!if2.in_ready && n < 300) begin @(negedge clk); n++; end
    if (!if2.in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send2_timeout: in_ready=%0b required 1", if2.in_ready);
    end
    @(posedge clk); #1;
    if2.in_valid = 1'b0; if2.in_a = 8'($urandom); if2.in_b = 8'($urandom); if2.in_last = 1'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (if0.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b required 0", if0.out_valid); end
    n_cmp++; if (if0.out_data !== 136'd0) begin n_bad++; $display("FAIL reset_out_data: got %0h required 0", if0.out_data); end
    n_cmp++; if (if0.out_count !== 16'd0) begin n_bad++; $display("FAIL reset_out_count: got %0d required 0", if0.out_count); end
    n_cmp++; if (if0.out_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_out_ovf: got %0b required 0", if0.out_ovf); end
    n_cmp++; if (if0.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0b required 1", if0.in_ready); end
    n_cmp++; if ((if1.out_valid | if2.out_valid) !== 1'b0) begin n_bad++; $display("FAIL reset_small_out_valid: got %0b/%0b required 0/0", if1.out_valid, if2.out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned_basic();
    int base, t_last;
    base = obs0.size();
    send0(64'd3, 64'd4, 1'b0); send0(64'd5, 64'd6, 1'b0); send0(64'd7, 64'd8, 1'b1);
    t_last = acc_cyc0;
    for (int k = 0; k < 100 && obs0.size() < base + 1; k++) @(posedge clk);
    #1;
    n_cmp++; if (obs0.size() < base + 1) begin n_bad++; $display("FAIL basic_timeout: got %0d results required 1", obs0.size() - base); end
    if (obs0.size() >= base + 1) begin
      n_cmp++; if (obs0[base].d !== 136'd98) begin n_bad++; $display("FAIL basic_data: got %0d required 98", obs0[base].d); end
      n_cmp++; if (obs0[base].c !== 16'd3) begin n_bad++; $display("FAIL basic_count: got %0d required 3", obs0[base].c); end
      n_cmp++; if (obs0[base].o !== 1'b0) begin n_bad++; $display("FAIL basic_ovf: got %0b required 0", obs0[base].o); end
      n_cmp++; if (obs0[base].cy != t_last + 3) begin n_bad++; $display("FAIL basic_latency: got cycle %0d required %0d", obs0[base].cy, t_last + 3); end
    end
    repeat (6) @(posedge clk); #1;
    n_cmp++; if (obs0.size() != base + 1) begin n_bad++; $display("FAIL basic_extra: got %0d results required 1", obs0.size() - base); end
  endtask

  task automatic test_signed();
    int base;
    base = obs1.size();
    send1(8'hFE, 8'd3, 1'b0); send1(8'd4, 8'd5, 1'b1); send1(8'h80, 8'd127, 1'b1);
    for (int k = 0; k < 100 && obs1.size() < base + 2; k++) @(posedge clk);
    #1;
    n_cmp++; if (obs1.size() < base + 2) begin n_bad++; $display("FAIL signed_timeout: got %0d results required 2", obs1.size() - base); end
    if (obs1.size() >= base + 2) begin
      n_cmp++; if (obs1[base].d !== 136'd14) begin n_bad++; $display("FAIL signed_data0: got %0h required e", obs1[base].d); end
      n_cmp++; if (obs1[base].c !== 16'd2) begin n_bad++; $display("FAIL signed_count0: got %0d required 2", obs1[base].c); end
      n_cmp++; if (obs1[base+1].d !== 136'hFFC080) begin n_bad++; $display("FAIL signed_data1: got %0h required ffc080", obs1[base+1].d); end
      n_cmp++; if (obs1[base+1].c !== 16'd1) begin n_bad++; $display("FAIL signed_count1: got %0d required 1", obs1[base+1].c); end
      n_cmp++; if (obs1[base+1].o !== 1'b0) begin n_bad++; $display("FAIL signed_ovf1: got %0b required 0", obs1[base+1].o); end
    end
  endtask

  task automatic test_guard0_overflow();
    int base;
    base = obs2.size();
    send2(8'd255, 8'd255, 1'b0); send2(8'd255, 8'd255, 1'b1); send2(8'd1, 8'd1, 1'b1);
    for (int k = 0; k < 100 && obs2.size() < base + 2; k++) @(posedge clk);
    #1;
    n_cmp++; if (obs2.size() < base + 2) begin n_bad++; $display("FAIL ovf_timeout: got %0d results required 2", obs2.size() - base); end
    if (obs2.size() >= base + 2) begin
      n_cmp++; if (obs2[base].d !== 136'd64514) begin n_bad++; $display("FAIL ovf_data0: got %0d required 64514", obs2[base].d); end
      n_cmp++; if (obs2[base].o !== 1'b1) begin n_bad++; $display("FAIL ovf_flag0: got %0b required 1", obs2[base].o); end
      n_cmp++; if (obs2[base].c !== 16'd2) begin n_bad++; $display("FAIL ovf_count0: got %0d required 2", obs2[base].c); end
      n_cmp++; if (obs2[base+1].d !== 136'd1) begin n_bad++; $display("FAIL ovf_data1: got %0d required 1", obs2[base+1].d); end
      n_cmp++; if (obs2[base+1].o !== 1'b0) begin n_bad++; $display("FAIL ovf_flag1: got %0b required 0", obs2[base+1].o); end
    end
  endtask

  task automatic test_backpressure();
    logic [135:0] ed[$];
    logic [15:0]  ec[$];
    int base;
    base = obs0.size();
    if0.out_ready = 1'b0;
    fork
      begin
        logic [63:0]  a, b;
        logic [135:0] s;
        int len;
        for (int v = 0; v < 3; v++) begin
          len = $urandom_range(1, 3);
          s = '0;
          for (int k = 0; k < len; k++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            s = s + {72'd0, a} * {72'd0, b};
            send0(a, b, k == len - 1);
          end
          ed.push_back(s); ec.push_back(16'(len));
        end
      end
      begin
        int n;
        n = 0;
        while (!if0.out_valid && n < 100) begin @(negedge clk); n++; end
        n_cmp++; if (!if0.out_valid) begin n_bad++; $display("FAIL bp_first_timeout: out_valid=%0b required 1", if0.out_valid); end
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          n_cmp++; if (if0.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_held: got %0b required 0", if0.in_ready); end
        end
        @(posedge clk); #1;
        if0.out_ready = 1'b1;
      end
    join
    for (int k = 0; k < 200 && obs0.size() < base + 3; k++) @(posedge clk);
    repeat (6) @(posedge clk); #1;
    n_cmp++; if (obs0.size() != base + 3) begin n_bad++; $display("FAIL bp_result_count: got %0d results required 3", obs0.size() - base); end
    for (int k = 0; k < 3 && base + k < obs0.size(); k++) begin
      n_cmp++; if (obs0[base+k].d !== ed[k]) begin n_bad++; $display("FAIL bp_data%0d: got %0h required %0h", k, obs0[base+k].d, ed[k]); end
      n_cmp++; if (obs0[base+k].c !== ec[k]) begin n_bad++; $display("FAIL bp_count%0d: got %0d required %0d", k, obs0[base+k].c, ec[k]); end
    end
  endtask

  task automatic test_reset_mid_vector();
    int base;
    logic seen;
    base = obs0.size();
    seen = 1'b0;
    send0(64'd9, 64'd9, 1'b0); send0(64'd10, 64'd10, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 8; k++) begin @(negedge clk); seen = seen | if0.out_valid; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_result: out_valid seen=%0b required 0", seen); end
    @(posedge clk); #1;
    send0(64'd2, 64'd2, 1'b1);
    for (int k = 0; k < 100 && obs0.size() < base + 1; k++) @(posedge clk);
    #1;
    n_cmp++; if (obs0.size() != base + 1) begin n_bad++; $display("FAIL rstmid_result_count: got %0d required 1", obs0.size() - base); end
    if (obs0.size() >= base + 1) begin
      n_cmp++; if (obs0[base].d !== 136'd4) begin n_bad++; $display("FAIL rstmid_data: got %0d required 4", obs0[base].d); end
      n_cmp++; if (obs0[base].c !== 16'd1) begin n_bad++; $display("FAIL rstmid_count: got %0d required 1", obs0[base].c); end
    end
  endtask

  task automatic test_back_to_back();
    int base, t_first;
    base = obs0.size();
    t_first = 0;
    for (int i = 1; i <= 8; i++) begin
      send0(64'(i), 64'(i), 1'b1);
      if (i == 1) t_first = acc_cyc0 + 3;
    end
    for (int k = 0; k < 100 && obs0.size() < base + 8; k++) @(posedge clk);
    #1;
    n_cmp++; if (obs0.size() < base + 8) begin n_bad++; $display("FAIL b2b_timeout: got %0d results required 8", obs0.size() - base); end
    for (int k = 0; k < 8 && base + k < obs0.size(); k++) begin
      n_cmp++; if (obs0[base+k].d !== 136'((k + 1) * (k + 1))) begin n_bad++; $display("FAIL b2b_data%0d: got %0d required %0d", k, obs0[base+k].d, (k + 1) * (k + 1)); end
      n_cmp++; if (obs0[base+k].c !== 16'd1) begin n_bad++; $display("FAIL b2b_count%0d: got %0d required 1", k, obs0[base+k].c); end
      n_cmp++; if (obs0[base+k].cy != t_first + k) begin n_bad++; $display("FAIL b2b_cycle%0d: got %0d required %0d", k, obs0[base+k].cy, t_first + k); end
    end
  endtask

  task automatic test_random_unsigned();
    logic [15:0] ed[$];
    int          ec[$];
    logic        eo[$];
    int base, nvec;
    logic done;
    base = obs2.size(); nvec = 30; done = 1'b0;
    fork
      begin
        longint s;
        logic [7:0] a, b;
        logic o;
        int len;
        for (int v = 0; v < nvec; v++) begin
          len = $urandom_range(1, 6); s = 0; o = 1'b0;
          for (int k = 0; k < len; k++) begin
            a = 8'($urandom); b = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            s = s + longint'(a) * longint'(b);
            if (s > 65535) o = 1'b1;
            send2(a, b, k == len - 1);
          end
          ed.push_back(16'(s)); ec.push_back(len); eo.push_back(o);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin @(posedge clk); #1; if2.out_ready = ($urandom_range(0, 2) != 0); end
        if2.out_ready = 1'b1;
      end
    join
    for (int k = 0; k < 3000 && obs2.size() < base + nvec; k++) @(posedge clk);
    repeat (6) @(posedge clk); #1;
    n_cmp++; if (obs2.size() != base + nvec) begin n_bad++; $display("FAIL rndu_count: got %0d results required %0d", obs2.size() - base, nvec); end
    for (int k = 0; k < nvec && base + k < obs2.size(); k++) begin
      n_cmp++; if (obs2[base+k].d !== 136'(ed[k])) begin n_bad++; $display("FAIL rndu_data%0d: got %0d required %0d", k, obs2[base+k].d, ed[k]); end
      n_cmp++; if (obs2[base+k].c !== 16'(ec[k])) begin n_bad++; $display("FAIL rndu_terms%0d: got %0d required %0d", k, obs2[base+k].c, ec[k]); end
      n_cmp++; if (obs2[base+k].o !== eo[k]) begin n_bad++; $display("FAIL rndu_ovf%0d: got %0b required %0b", k, obs2[base+k].o, eo[k]); end
    end
  endtask

  task automatic test_random_signed();
    logic [23:0] ed[$];
    int          ec[$];
    logic        eo[$];
    int base, nvec;
    logic done;
    base = obs1.size(); nvec = 30; done = 1'b0;
    fork
      begin
        int s, len;
        byte sa, sb;
        logic o;
        for (int v = 0; v < nvec; v++) begin
          len = $urandom_range(1, 6); s = 0; o = 1'b0;
          for (int k = 0; k < len; k++) begin
            sa = byte'($urandom); sb = byte'($urandom);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            s = s + int'(sa) * int'(sb);
            if (s > 8388607 || s < -8388608) o = 1'b1;
            send1(8'(sa), 8'(sb), k == len - 1);
          end
          ed.push_back(24'(s)); ec.push_back(len); eo.push_back(o);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin @(posedge clk); #1; if1.out_ready = ($urandom_range(0, 2) != 0); end
        if1.out_ready = 1'b1;
      end
    join
    for (int k = 0; k < 3000 && obs1.size() < base + nvec; k++) @(posedge clk);
    repeat (6) @(posedge clk); #1;
    n_cmp++; if (obs1.size() != base + nvec) begin n_bad++; $display("FAIL rnds_count: got %0d results required %0d", obs1.size() - base, nvec); end
    for (int k = 0; k < nvec && base + k < obs1.size(); k++) begin
      n_cmp++; if (obs1[base+k].d !== 136'(ed[k])) begin n_bad++; $display("FAIL rnds_data%0d: got %0h required %0h", k, obs1[base+k].d, ed[k]); end
      n_cmp++; if (obs1[base+k].c !== 16'(ec[k])) begin n_bad++; $display("FAIL rnds_terms%0d: got %0d required %0d", k, obs1[base+k].c, ec[k]); end
      n_cmp++; if (obs1[base+k].o !== eo[k]) begin n_bad++; $display("FAIL rnds_ovf%0d: got %0b required %0b", k, obs1[base+k].o, eo[k]); end
    end
  endtask

  initial begin
    if0.in_valid = 1'b0; if0.in_a = '0; if0.in_b = '0; if0.in_last = 1'b0; if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_a = '0; if1.in_b = '0; if1.in_last = 1'b0; if1.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.in_a = '0; if2.in_b = '0; if2.in_last = 1'b0; if2.out_ready = 1'b1;
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_guard0_overflow();
    test_backpressure();
    test_reset_mid_vector();
    test_back_to_back();
    test_random_unsigned();
    test_random_signed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
